pudding_chain_loader: RTL

PUDDING_CHAIN_LOADER -- requirements
Module: pudding_chain_loader

---
 rtl/pudding_chain_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pudding_chain_loader.sv
// Loads a thermometer code serially into a DAC unit-cell daisychain, then transfers it to the cell state.
// Define PUDDING_LOADER_READBACK_EN to add a state->chain readback pass that flags mismatches on rb_err.
module pudding_chain_loader #(
    parameter int CHAIN_LEN = 128,
    parameter int CODE_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [CODE_W-1:0] code,
    output logic              datum,
    output logic              shift,
    output logic              transfer,
    output logic              dir,
    input  logic              sdo,
    output logic              busy,
    output logic              done,
    output logic              rb_err
);
    localparam int                CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_K   = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0]  RB_END   = CNT_W'(CHAIN_LEN);
    localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(CHAIN_LEN);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        XFER,
`ifdef PUDDING_LOADER_READBACK_EN
        RB_CAP,
        RB_SHIFT,
`endif
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                shift_q, shift_d;
    logic                datum_q, datum_d;
    logic                transfer_q, transfer_d;
    logic                dir_q, dir_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                code_ready_q, code_ready_d;
    logic                accept;

    // Bit shifted in during step k lands at chain position CHAIN_LEN-1-k.
    function automatic logic thermo_bit(input logic [CNT_W-1:0] k, input logic [CODE_W-1:0] c);
        logic [31:0] pos;
        pos = 32'(CHAIN_LEN - 1) - 32'(k);
        return pos < 32'(c);
    endfunction

    assign accept = code_valid && code_ready_q;

`ifdef PUDDING_LOADER_READBACK_EN
    logic rb_hit;
    logic rb_err_q, rb_err_d;
`else
    logic unused_sdo;
    assign unused_sdo = sdo;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
`ifdef PUDDING_LOADER_READBACK_EN
        rb_hit  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    code_d  = (code > CODE_MAX) ? CODE_MAX : code;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_K) state_d = XFER;
                else                 cnt_d   = cnt_q + CNT_W'(1);
            end
            XFER: begin
`ifdef PUDDING_LOADER_READBACK_EN
                state_d = RB_CAP;
`else
                state_d = DONE;
`endif
            end
`ifdef PUDDING_LOADER_READBACK_EN
            RB_CAP: begin
                state_d = RB_SHIFT;
                cnt_d   = '0;
            end
            // Extra trailing cycle lets the last compare settle into rb_err before done.
            RB_SHIFT: begin
                if (cnt_q == RB_END) begin
                    state_d = DONE;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    rb_hit = (sdo != thermo_bit(cnt_q, code_q));
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        shift_d      = (state_d == SHIFT);
        datum_d      = (state_d == SHIFT) && thermo_bit(cnt_d, code_d);
        transfer_d   = (state_d == XFER);
        dir_d        = (state_d == XFER);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        code_ready_d = (state_d == IDLE);
`ifdef PUDDING_LOADER_READBACK_EN
        if (state_d == RB_SHIFT && cnt_d != RB_END) shift_d = 1'b1;
        if (state_d == RB_CAP) transfer_d = 1'b1;
        rb_err_d = accept ? 1'b0 : (rb_err_q | rb_hit);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            code_q       <= '0;
            shift_q      <= 1'b0;
            datum_q      <= 1'b0;
            transfer_q   <= 1'b0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            code_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            shift_q      <= shift_d;
            datum_q      <= datum_d;
            transfer_q   <= transfer_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            code_ready_q <= code_ready_d;
        end
    end

`ifdef PUDDING_LOADER_READBACK_EN
    always_ff @(posedge clk) begin
        if (rst) rb_err_q <= 1'b0;
        else     rb_err_q <= rb_err_d;
    end
    assign rb_err = rb_err_q;
`else
    assign rb_err = 1'b0;
`endif

    assign code_ready = code_ready_q;
    assign datum      = datum_q;
    assign shift      = shift_q;
    assign transfer   = transfer_q;
    assign dir        = dir_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
